// File: rtl/sprite_blitter.sv
// Sprite draw engine: scans a SPRITE_W x SPRITE_H colour ROM in row-major
// order after a start pulse and emits one plot request per visible pixel at
// the latched origin. It supports clipping at the screen edges, skipping of a
// transparent colour, and an erase mode that fills with a solid colour.
module sprite_blitter #(
  parameter int SPRITE_W = 10,
  parameter int SPRITE_H = 10,
  parameter int COORD_W  = 11,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COLOR_W  = 3,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
  localparam int ADDR_W = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic               erase,
  input  logic [COLOR_W-1:0] erase_color,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  // Counter widths; a one-pixel dimension still needs a one-bit counter.
  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  // Screen limits at the width of the extended coordinate sums.
  localparam logic [COORD_W:0] X_LIMIT = (COORD_W + 1)'(SCREEN_W);
  localparam logic [COORD_W:0] Y_LIMIT = (COORD_W + 1)'(SCREEN_H);

  // Last column and row indices at counter width.
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t state;

  // Scan position: row/col counters run alongside the linear ROM address,
  // so no divide or modulo is needed anywhere.
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;

  // Draw parameters captured when a start is accepted.
  logic [COORD_W-1:0] org_x;
  logic [COORD_W-1:0] org_y;
  logic               erase_mode;
  logic [COLOR_W-1:0] fill_color;

  // Pipeline stage aligned with the ROM's one-cycle read latency.
  logic [COL_W-1:0] pipe_col;
  logic [ROW_W-1:0] pipe_row;
  logic             pipe_valid;

  logic busy_flag;
  logic done_flag;

  // Datapath intermediates for the plot slot.
  logic [COORD_W:0]   sum_x;
  logic [COORD_W:0]   sum_y;
  logic               on_screen;
  logic               opaque;
  logic [COLOR_W-1:0] pixel_colour;

  // Control FSM: accepts start, scans the sprite, drains the last pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      org_x      <= '0;
      org_y      <= '0;
      erase_mode <= 1'b0;
      fill_color <= '0;
      pipe_col   <= '0;
      pipe_row   <= '0;
      pipe_valid <= 1'b0;
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pipe_valid <= 1'b0;
          done_flag  <= 1'b0;
          if (start) begin
            org_x      <= origin_x;
            org_y      <= origin_y;
            erase_mode <= erase;
            fill_color <= erase_color;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            busy_flag  <= 1'b1;
            state      <= SCAN;
          end
        end

        SCAN: begin
          // Record the position of the address issued this cycle; its ROM
          // data appears next cycle together with this stage.
          pipe_col   <= col;
          pipe_row   <= row;
          pipe_valid <= 1'b1;
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              // Final address already issued; hold it and drain.
              done_flag <= 1'b1;
              state     <= LAST;
            end else begin
              row  <= row + ROW_W'(1);
              addr <= addr + ADDR_W'(1);
            end
          end else begin
            col  <= col + COL_W'(1);
            addr <= addr + ADDR_W'(1);
          end
        end

        LAST: begin
          // Final pixel is presented during this cycle; start is ignored.
          pipe_valid <= 1'b0;
          done_flag  <= 1'b0;
          busy_flag  <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          pipe_valid <= 1'b0;
          done_flag  <= 1'b0;
          busy_flag  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Pixel datapath: screen coordinate, clipping, transparency and colour.
  always_comb begin
    sum_x = {1'b0, org_x} + (COORD_W + 1)'(pipe_col);
    sum_y = {1'b0, org_y} + (COORD_W + 1)'(pipe_row);
    // A carry out means the coordinate wrapped past the coordinate range.
    on_screen = !sum_x[COORD_W] && !sum_y[COORD_W] &&
                (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
    opaque       = erase_mode || (rom_data != TRANSPARENT);
    pixel_colour = erase_mode ? fill_color : rom_data;

    // Outputs are held at zero outside a valid slot so they clear with reset.
    plot   = pipe_valid && on_screen && opaque;
    x      = pipe_valid ? sum_x[COORD_W-1:0] : '0;
    y      = pipe_valid ? sum_y[COORD_W-1:0] : '0;
    colour = pipe_valid ? pixel_colour : '0;
  end

  assign rom_addr = addr;
  assign busy     = busy_flag;
  assign done     = done_flag;

endmodule
